// File: rtl/i2c_passthru_pkg.sv
// Shared definitions for the I2C pass-through byte sequencer.
// Contents: FSM state encoding, SDA direction constants, frame slot
// indices and helpers that decide who drives SDA in a slot.
package i2c_passthru_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_REQ,
        ST_LAUNCH,
        ST_WAIT_ACCEPT,
        ST_WAIT_DONE,
        ST_WAIT_STOP,
        ST_ERROR
    } state_t;

    localparam logic DIR_TO_SLV = 1'b0;  // master drives SDA toward slave
    localparam logic DIR_TO_MST = 1'b1;  // slave drives SDA toward master

    localparam logic [3:0] BIT_RW  = 4'd7;  // R/W bit of the address frame
    localparam logic [3:0] BIT_ACK = 4'd8;  // ACK slot of every frame

    // States in which a bit is in flight on the transmitter.
    function automatic logic is_active(input state_t s);
        return (s == ST_LAUNCH) || (s == ST_WAIT_ACCEPT) || (s == ST_WAIT_DONE);
    endfunction

    // Data bits flow from the byte sender; the ACK comes from the receiver.
    // Only read data frames are sent by the slave.
    function automatic logic tx_dir(input logic in_addr, input logic is_read,
                                    input logic [3:0] bit_cnt);
        logic slave_sends;
        slave_sends = !in_addr && is_read;
        if (bit_cnt == BIT_ACK)
            return slave_sends ? DIR_TO_SLV : DIR_TO_MST;
        return slave_sends ? DIR_TO_MST : DIR_TO_SLV;
    endfunction

endpackage

// File: rtl/i2c_passthru_byte_seq_if.sv
// Link between the byte sequencer (master side) and its watchdog (slave side).
//   clr     : restart the count at zero
//   en      : count this cycle
//   expired : count has reached the limit (saturated)
interface i2c_passthru_byte_seq_if;
    logic clr;
    logic en;
    logic expired;

    modport master (output clr, output en, input expired);
    modport slave  (input clr, input en, output expired);
endinterface

// File: rtl/i2c_passthru_watchdog.sv
// Saturating per-bit watchdog counter.
// Ports:
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   wd (slave)    : clr / en in, expired out
// The count stops at LIMIT so expired stays asserted until the next clear.
module i2c_passthru_watchdog #(
    parameter int unsigned LIMIT = 2000,
    parameter int unsigned WIDTH = 11
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    i2c_passthru_byte_seq_if.slave wd
);

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            cnt <= '0;
        else if (wd.clr)
            cnt <= '0;
        else if (wd.en && (cnt != LIMIT_W))
            cnt <= cnt + WIDTH'(1);
    end

    assign wd.expired = (cnt == LIMIT_W);

endmodule

// File: rtl/i2c_passthru_byte_seq.sv
// I2C pass-through byte sequencer: tracks START/STOP and per-bit requests
// from the bus, launches the bit transmitter once per slot, tracks the
// address/data frame position and ACK/NACK, and guards each bit with a
// watchdog.
// Ports:
//   i_clk, i_rstn        : clock, asynchronous active-low reset
//   i_start_det/stop_det : bus START (or repeated START) / STOP pulses
//   i_bit_req            : next bit slot open
//   i_rx_bit, i_tx_done, i_violation : bit transmitter status
//   o_start_tx, o_tx_is_to_mst       : bit transmitter launch and direction
//   o_bit_cnt, o_is_read, o_in_addr, o_busy : frame position / status
//   o_nack (pulse), o_timeout, o_error (sticky until START/STOP)
module i2c_passthru_byte_seq
    import i2c_passthru_pkg::*;
#(
    parameter int unsigned F_REF_T_TIMEOUT       = 2000,
    parameter int unsigned WIDTH_F_REF_T_TIMEOUT = 11
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_start_det,
    input  logic       i_stop_det,
    input  logic       i_bit_req,
    input  logic       i_rx_bit,
    input  logic       i_tx_done,
    input  logic       i_violation,
    output logic       o_start_tx,
    output logic       o_tx_is_to_mst,
    output logic [3:0] o_bit_cnt,
    output logic       o_is_read,
    output logic       o_in_addr,
    output logic       o_busy,
    output logic       o_nack,
    output logic       o_timeout,
    output logic       o_error
);

    state_t     state, state_nxt;
    logic [3:0] bit_cnt, bit_cnt_nxt;
    logic       is_read, is_read_nxt;
    logic       in_addr, in_addr_nxt;
    logic       start_tx, start_tx_nxt;
    logic       nack, nack_nxt;
    logic       timeout, timeout_nxt;
    logic       error, error_nxt;
    logic       wd_clr;
    logic       active;

    i2c_passthru_byte_seq_if wd_if ();

    i2c_passthru_watchdog #(
        .LIMIT (F_REF_T_TIMEOUT),
        .WIDTH (WIDTH_F_REF_T_TIMEOUT)
    ) u_watchdog (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .wd     (wd_if.slave)
    );

    assign active    = is_active(state);
    assign wd_if.clr = wd_clr;
    assign wd_if.en  = active;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            is_read  <= 1'b0;
            in_addr  <= 1'b0;
            start_tx <= 1'b0;
            nack     <= 1'b0;
            timeout  <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            is_read  <= is_read_nxt;
            in_addr  <= in_addr_nxt;
            start_tx <= start_tx_nxt;
            nack     <= nack_nxt;
            timeout  <= timeout_nxt;
            error    <= error_nxt;
        end
    end

    // Bus events, then transmitter faults, then normal sequencing.
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        is_read_nxt  = is_read;
        in_addr_nxt  = in_addr;
        start_tx_nxt = 1'b0;
        nack_nxt     = 1'b0;
        timeout_nxt  = timeout;
        error_nxt    = error;
        wd_clr       = 1'b0;

        if (i_stop_det) begin
            state_nxt   = ST_IDLE;
            bit_cnt_nxt = '0;
            is_read_nxt = 1'b0;
            in_addr_nxt = 1'b0;
            timeout_nxt = 1'b0;
            error_nxt   = 1'b0;
        end else if (i_start_det) begin
            state_nxt   = ST_WAIT_REQ;
            bit_cnt_nxt = '0;
            is_read_nxt = 1'b0;
            in_addr_nxt = 1'b1;
            timeout_nxt = 1'b0;
            error_nxt   = 1'b0;
        end else if (active && i_violation) begin
            state_nxt = ST_ERROR;
            error_nxt = 1'b1;
        end else if (active && wd_if.expired) begin
            state_nxt   = ST_ERROR;
            timeout_nxt = 1'b1;
        end else begin
            case (state)
                ST_WAIT_REQ: begin
                    if (i_bit_req) begin
                        state_nxt = ST_LAUNCH;
                        wd_clr    = 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    if (i_tx_done) begin
                        start_tx_nxt = 1'b1;
                        state_nxt    = ST_WAIT_ACCEPT;
                    end
                end
                ST_WAIT_ACCEPT: begin
                    if (!i_tx_done)
                        state_nxt = ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (i_tx_done) begin
                        if (bit_cnt == BIT_ACK) begin
                            if (i_rx_bit) begin
                                nack_nxt  = 1'b1;
                                state_nxt = ST_WAIT_STOP;
                            end else begin
                                bit_cnt_nxt = '0;
                                in_addr_nxt = 1'b0;
                                state_nxt   = ST_WAIT_REQ;
                            end
                        end else begin
                            if (in_addr && (bit_cnt == BIT_RW))
                                is_read_nxt = i_rx_bit;
                            bit_cnt_nxt = bit_cnt + 4'd1;
                            state_nxt   = ST_WAIT_REQ;
                        end
                    end
                end
                default: ;  // IDLE, WAIT_STOP, ERROR wait for START/STOP
            endcase
        end
    end

    assign o_start_tx     = start_tx;
    assign o_tx_is_to_mst = active ? tx_dir(in_addr, is_read, bit_cnt) : DIR_TO_SLV;
    assign o_bit_cnt      = bit_cnt;
    assign o_is_read      = is_read;
    assign o_in_addr      = in_addr;
    assign o_busy         = (state != ST_IDLE);
    assign o_nack         = nack;
    assign o_timeout      = timeout;
    assign o_error        = error;

endmodule

// File: tb/tb_i2c_passthru_byte_seq.sv
// Self-checking bench for i2c_passthru_byte_seq: acts as bus master and bit
// transmitter, drives table-driven and random transactions, and compares
// against an I2C-level reference of who drives each slot and how many
// launches a transaction takes.
module tb_i2c_passthru_byte_seq;

    localparam int unsigned TO  = 40;
    localparam int unsigned TOW = 6;

    logic       i_clk = 1'b0;
    logic       i_rstn, i_start_det, i_stop_det, i_bit_req;
    logic       i_rx_bit, i_tx_done, i_violation;
    logic       o_start_tx, o_tx_is_to_mst, o_is_read, o_in_addr, o_busy;
    logic       o_nack, o_timeout, o_error;
    logic [3:0] o_bit_cnt;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    i2c_passthru_byte_seq #(
        .F_REF_T_TIMEOUT       (TO),
        .WIDTH_F_REF_T_TIMEOUT (TOW)
    ) dut (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .i_start_det    (i_start_det),
        .i_stop_det     (i_stop_det),
        .i_bit_req      (i_bit_req),
        .i_rx_bit       (i_rx_bit),
        .i_tx_done      (i_tx_done),
        .i_violation    (i_violation),
        .o_start_tx     (o_start_tx),
        .o_tx_is_to_mst (o_tx_is_to_mst),
        .o_bit_cnt      (o_bit_cnt),
        .o_is_read      (o_is_read),
        .o_in_addr      (o_in_addr),
        .o_busy         (o_busy),
        .o_nack         (o_nack),
        .o_timeout      (o_timeout),
        .o_error        (o_error)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0]       addr;
        int unsigned      ndata;
        logic [2:0][7:0]  data;
        logic [3:0]       acks;   // ack bit per frame, frame 0 = address
    } txn_t;

    typedef struct {
        txn_t        t;
        int unsigned exp_launches;
        logic        exp_read;
        int unsigned exp_nacks;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {19'd0, o_start_tx, o_tx_is_to_mst, o_bit_cnt, o_is_read, o_in_addr,
                o_busy, o_nack, o_timeout, o_error};
    endfunction

    // Byte sender drives data bits, byte receiver drives the ACK.
    function automatic logic exp_dir(input int frame, input logic rd, input int slot);
        logic slave_sends_byte;
        slave_sends_byte = (frame > 0) && rd;
        return (slot == 8) ? !slave_sends_byte : slave_sends_byte;
    endfunction

    // Each frame takes 9 launches; the first NACKed frame ends the transfer.
    function automatic void model(input txn_t t, output int unsigned launches,
                                  output int unsigned nacks);
        launches = 0;
        nacks    = 0;
        for (int f = 0; f <= int'(t.ndata); f++) begin
            launches += 9;
            if (t.acks[f]) begin
                nacks = 1;
                break;
            end
        end
    endfunction

    function automatic vec_t mk(input logic [7:0] a, input int unsigned n, input logic [23:0] d,
                                input logic [3:0] k, input int unsigned el, input logic rd,
                                input int unsigned nk);
        vec_t v;
        v.t.addr = a; v.t.ndata = n; v.t.data = d; v.t.acks = k;
        v.exp_launches = el; v.exp_read = rd; v.exp_nacks = nk;
        return v;
    endfunction

    task automatic pulse(output logic launched);
        i_bit_req = 1'b1;
        cyc();
        i_bit_req = 1'b0;
        launched = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (o_start_tx) begin
                launched = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic finish_bit(input logic rx);
        i_tx_done = 1'b0;
        cyc();
        check("start_tx_one_cycle", o_start_tx, 1'b0);
        repeat ($urandom_range(0, 2)) cyc();
        i_rx_bit  = rx;
        i_tx_done = 1'b1;
        cyc();
    endtask

    task automatic start_cond();
        i_start_det = 1'b1;
        cyc();
        i_start_det = 1'b0;
    endtask

    task automatic stop_cond();
        i_stop_det = 1'b1;
        cyc();
        i_stop_det = 1'b0;
    endtask

    task automatic run_txn(input txn_t t, input logic end_stop, output int unsigned launches,
                           output int unsigned nacks, output logic rd_seen);
        logic       launched;
        logic       stopped;
        logic [7:0] byte_v;
        logic       bitv;
        launches = 0; nacks = 0; stopped = 1'b0; rd_seen = 1'b0;
        start_cond();
        check("start_bit_cnt", o_bit_cnt, 4'd0);
        check("start_in_addr", o_in_addr, 1'b1);
        check("start_busy", o_busy, 1'b1);
        for (int f = 0; f <= int'(t.ndata) && !stopped; f++) begin
            if (f == 0) byte_v = t.addr;
            else        byte_v = t.data[f-1];
            for (int s = 0; s < 9 && !stopped; s++) begin
                bitv = (s < 8) ? byte_v[7-s] : t.acks[f];
                pulse(launched);
                check("launch", launched, 1'b1);
                if (!launched) begin
                    stopped = 1'b1;
                end else begin
                    launches++;
                    check("bit_cnt", o_bit_cnt, s);
                    check("in_addr", o_in_addr, f == 0);
                    check("tx_dir", o_tx_is_to_mst, exp_dir(f, t.addr[0], s));
                    finish_bit(bitv);
                    if (s == 8) begin
                        if (o_nack) nacks++;
                        check("nack_pulse", o_nack, t.acks[f]);
                        if (t.acks[f]) stopped = 1'b1;
                    end
                    if (f == 0 && s == 7) rd_seen = o_is_read;
                end
            end
        end
        if (nacks != 0) begin
            pulse(launched);
            if (launched) launches++;
            check("wait_stop_busy", o_busy, 1'b1);
        end
        if (end_stop) begin
            stop_cond();
            check("stop_idle", all_outs(), 32'd0);
        end
    endtask

    vec_t        vecs[5];
    txn_t        rt;
    int unsigned act_l, act_n, exp_l, exp_n, n;
    logic        rd, launched;

    initial begin
        #5_000_000;
        $display("FAIL global_time_limit: got still running expected finished");
        $fatal(1);
    end

    initial begin
        i_rstn = 1'b0; i_start_det = 1'b0; i_stop_det = 1'b0; i_bit_req = 1'b0;
        i_rx_bit = 1'b0; i_tx_done = 1'b1; i_violation = 1'b0;
        cyc(); cyc();
        check("reset_outputs", all_outs(), 32'd0);
        i_rstn = 1'b1;
        cyc();
        check("idle_after_reset", all_outs(), 32'd0);
        pulse(launched);
        check("idle_ignores_bit_req", launched, 1'b0);

        vecs[0] = mk(8'hA0, 1, 24'h000055, 4'b0000, 18, 1'b0, 0);
        vecs[1] = mk(8'hA1, 1, 24'h00003C, 4'b0010, 18, 1'b1, 1);
        vecs[2] = mk(8'hA0, 1, 24'h000055, 4'b0001,  9, 1'b0, 1);
        vecs[3] = mk(8'h5B, 2, 24'h00FF00, 4'b0000, 27, 1'b1, 0);
        vecs[4] = mk(8'h42, 3, 24'hC3A512, 4'b0100, 27, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].t, 1'b1, act_l, act_n, rd);
            check("vec_launches", act_l, vecs[i].exp_launches);
            check("vec_is_read", rd, vecs[i].exp_read);
            check("vec_nacks", act_n, vecs[i].exp_nacks);
        end

        // Address NACK then repeated START restarts the address frame.
        run_txn(vecs[2].t, 1'b0, act_l, act_n, rd);
        check("nack_launches", act_l, 9);
        start_cond();
        check("rstart_bit_cnt", o_bit_cnt, 4'd0);
        check("rstart_in_addr", o_in_addr, 1'b1);
        pulse(launched);
        check("rstart_launch", launched, 1'b1);
        check("rstart_launch_cnt", o_bit_cnt, 4'd0);
        if (launched) finish_bit(1'b1);
        stop_cond();

        // Random transactions against the frame-level model.
        for (int i = 0; i < 20; i++) begin
            rt.addr  = 8'($urandom);
            rt.ndata = $urandom_range(1, 3);
            rt.data  = 24'($urandom);
            for (int f = 0; f < 4; f++) rt.acks[f] = ($urandom_range(0, 3) == 0);
            model(rt, exp_l, exp_n);
            run_txn(rt, 1'b1, act_l, act_n, rd);
            check("rnd_launches", act_l, exp_l);
            check("rnd_nacks", act_n, exp_n);
            check("rnd_is_read", rd, rt.addr[0]);
        end

        // Watchdog: transmitter never accepts the launch.
        start_cond();
        pulse(launched);
        check("to_launch", launched, 1'b1);
        n = 0;
        while (!o_timeout && n < 3 * TO) begin
            cyc();
            n++;
        end
        check("timeout_set", o_timeout, 1'b1);
        check("timeout_latency", (n >= TO - 2) && (n <= TO + 2), 1'b1);
        check("timeout_no_error", o_error, 1'b0);
        check("timeout_busy", o_busy, 1'b1);
        pulse(launched);
        check("error_ignores_bit_req", launched, 1'b0);
        stop_cond();
        check("timeout_cleared", all_outs(), 32'd0);

        // Violation together with STOP: STOP wins.
        start_cond();
        pulse(launched);
        i_tx_done = 1'b0;
        cyc();
        i_violation = 1'b1; i_stop_det = 1'b1;
        cyc();
        i_violation = 1'b0; i_stop_det = 1'b0;
        check("viol_stop_error", o_error, 1'b0);
        check("viol_stop_busy", o_busy, 1'b0);
        i_tx_done = 1'b1;
        cyc();

        // Violation alone: sticky error until START.
        start_cond();
        pulse(launched);
        i_tx_done = 1'b0;
        cyc();
        i_violation = 1'b1;
        cyc();
        i_violation = 1'b0;
        i_tx_done = 1'b1;
        check("viol_error", o_error, 1'b1);
        pulse(launched);
        check("viol_no_launch", launched, 1'b0);
        check("viol_error_sticky", o_error, 1'b1);
        start_cond();
        check("viol_cleared_by_start", o_error, 1'b0);
        check("viol_start_in_addr", o_in_addr, 1'b1);
        stop_cond();

        // Reset during bit 4 of the address frame.
        start_cond();
        for (int s = 0; s < 4; s++) begin
            pulse(launched);
            if (launched) finish_bit(s[0] ? 1'b0 : 1'b1);
        end
        check("pre_reset_bit_cnt", o_bit_cnt, 4'd4);
        pulse(launched);
        i_tx_done = 1'b0;
        cyc();
        i_rstn = 1'b0;
        #1;
        check("async_reset_outputs", all_outs(), 32'd0);
        cyc();
        i_rstn = 1'b1;
        i_tx_done = 1'b1;
        cyc();
        pulse(launched);
        check("post_reset_no_launch", launched, 1'b0);
        check("post_reset_idle", all_outs(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
